// File: rtl/simon_pkg.sv
// Shared types for the Simon controller.
// State encoding and per-state mode LED patterns.
package simon_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_INPUT,
        S_PLAYBACK,
        S_REPEAT,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_INIT     = 3'b000;
    localparam logic [2:0] MODE_INPUT    = 3'b001;
    localparam logic [2:0] MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] MODE_REPEAT   = 3'b100;
    localparam logic [2:0] MODE_DONE     = 3'b111;

    function automatic logic [2:0] mode_of(state_t s);
        logic [2:0] m;
        m = MODE_INIT;
        unique case (s)
            S_INIT:     m = MODE_INIT;
            S_INPUT:    m = MODE_INPUT;
            S_PLAYBACK: m = MODE_PLAYBACK;
            S_REPEAT:   m = MODE_REPEAT;
            S_DONE:     m = MODE_DONE;
            default:    m = MODE_INIT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/simon_control_dwell_timer.sv
// Per-entry dwell counter for pattern display.
// Counts 0..PLAY_CYCLES-1, pulses expire on the last cycle.
module simon_dwell_timer #(
    parameter int PLAY_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic expire
);

    localparam int W = (PLAY_CYCLES > 1) ? $clog2(PLAY_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(PLAY_CYCLES - 1);

    logic [W-1:0] cnt_q;

    assign expire = (cnt_q == LAST);

    // Wrap after the last dwell cycle; restart aligns a fresh dwell.
    always_ff @(posedge clk) begin
        if (rst || restart || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/simon_control.sv
// Simon game controller: FSM, press edge detect, entry count.
// Controls are decoded combinationally from state and press.
module simon_control
    import simon_pkg::*;
#(
    parameter int PLAY_CYCLES = 4,
    parameter int HARD_WIN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       curr_eq_last,
    input  logic       ptrn_eq_input,
    input  logic       is_legal,
    input  logic       curr_level,
    output logic       level_ld,
    output logic       first_ld,
    output logic       first_clr,
    output logic       last_ld,
    output logic       last_clr,
    output logic       curr_ld,
    output logic       curr_set,
    output logic       show_input,
    output logic       w_en,
    output logic [2:0] mode_leds
);

    localparam logic [5:0] HW = 6'(HARD_WIN);

    state_t     state_q, state_d, cur;
    logic       valid_q;
    logic       start_q, start_d;
    logic [5:0] count_q, count_d;
    logic       press, expire, restart, replay;

    // Reset forces INIT decoding so controls are valid while held.
    assign cur   = rst ? S_INIT : state_q;
    assign press = valid & ~valid_q & ~rst;

    // Next-state, count and control decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        replay     = 1'b0;
        level_ld   = 1'b0;
        first_ld   = 1'b0;
        first_clr  = 1'b0;
        last_ld    = 1'b0;
        last_clr   = 1'b0;
        curr_ld    = 1'b0;
        curr_set   = 1'b0;
        show_input = 1'b0;
        w_en       = 1'b0;
        mode_leds  = mode_of(cur);
        unique case (cur)
            S_INIT: begin
                level_ld  = 1'b1;
                first_clr = 1'b1;
                last_clr  = 1'b1;
                count_d   = '0;
                state_d   = S_INPUT;
            end
            S_INPUT: begin
                show_input = 1'b1;
                if (press && is_legal &&
                    (curr_level || count_q != 6'd63)) begin
                    w_en     = 1'b1;
                    last_ld  = 1'b1;
                    curr_ld  = 1'b1;
                    curr_set = 1'b1;
                    if (curr_level && count_q >= HW) begin
                        first_ld = 1'b1;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                    state_d = S_PLAYBACK;
                end
            end
            S_PLAYBACK: begin
                if (start_q && curr_eq_last) begin
                    curr_ld  = 1'b1;
                    curr_set = 1'b1;
                    state_d  = S_REPEAT;
                end else if (expire) begin
                    curr_ld = 1'b1;
                end
            end
            S_REPEAT: begin
                show_input = 1'b1;
                if (curr_eq_last) begin
                    state_d = S_INPUT;
                end else if (press) begin
                    curr_ld = 1'b1;
                    if (!ptrn_eq_input) begin
                        curr_set = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start_q && curr_eq_last) begin
                    curr_ld  = 1'b1;
                    curr_set = 1'b1;
                    replay   = 1'b1;
                end else if (expire) begin
                    curr_ld = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // A new dwell begins on state entry, replay, or after expiry.
    assign restart = rst | (state_d != state_q) | replay;
    assign start_d = restart | expire;

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            count_q <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid;
            start_q <= start_d;
        end
    end

    simon_dwell_timer #(
        .PLAY_CYCLES(PLAY_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .expire (expire)
    );

endmodule

// File: tb/tb_simon_control.sv
// Directed bench for simon_control.
// Vector table plus hand sequences for multi-cycle corners.
module tb_simon_control;
    import simon_pkg::*;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       curr_eq_last;
    logic       ptrn_eq_input;
    logic       is_legal;
    logic       curr_level;
    logic       level_ld, first_ld, first_clr, last_ld, last_clr;
    logic       curr_ld, curr_set, show_input, w_en;
    logic [2:0] mode_leds;

    int checks;
    int failures;

    simon_control #(
        .PLAY_CYCLES(4),
        .HARD_WIN   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .curr_eq_last (curr_eq_last),
        .ptrn_eq_input(ptrn_eq_input),
        .is_legal     (is_legal),
        .curr_level   (curr_level),
        .level_ld     (level_ld),
        .first_ld     (first_ld),
        .first_clr    (first_clr),
        .last_ld      (last_ld),
        .last_clr     (last_clr),
        .curr_ld      (curr_ld),
        .curr_set     (curr_set),
        .show_input   (show_input),
        .w_en         (w_en),
        .mode_leds    (mode_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {level_ld first_ld first_clr last_ld last_clr curr_ld
    //  curr_set show_input w_en mode_leds[2:0]}
    localparam logic [11:0] O_INIT    = 12'b1010_1000_0000;
    localparam logic [11:0] O_IN      = 12'b0000_0001_0001;
    localparam logic [11:0] O_IN_WR   = 12'b0001_0111_1001;
    localparam logic [11:0] O_PB      = 12'b0000_0000_0010;
    localparam logic [11:0] O_PB_ADV  = 12'b0000_0100_0010;
    localparam logic [11:0] O_PB_END  = 12'b0000_0110_0010;
    localparam logic [11:0] O_RP      = 12'b0000_0001_0100;
    localparam logic [11:0] O_RP_ADV  = 12'b0000_0101_0100;
    localparam logic [11:0] O_RP_FAIL = 12'b0000_0111_0100;
    localparam logic [11:0] O_DN      = 12'b0000_0000_0111;
    localparam logic [11:0] O_DN_ADV  = 12'b0000_0100_0111;
    localparam logic [11:0] O_DN_RST  = 12'b0000_0110_0111;

    typedef struct {
        logic        r;
        logic        v;
        logic        cel;
        logic        pei;
        logic        leg;
        logic        lvl;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl[NV];

    function automatic logic [11:0] obs();
        return {level_ld, first_ld, first_clr, last_ld, last_clr,
                curr_ld, curr_set, show_input, w_en, mode_leds};
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(logic r, logic v, logic c, logic p,
                         logic l, logic lv);
        rst           = r;
        valid         = v;
        curr_eq_last  = c;
        ptrn_eq_input = p;
        is_legal      = l;
        curr_level    = lv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    int wcount;

    initial begin
        checks   = 0;
        failures = 0;
        drive(1, 0, 0, 0, 0, 0);

        //         r  v  cel pei leg lvl exp
        tbl[0]  = '{1, 0, 0, 0, 0, 0, O_INIT};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, O_INIT};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, O_INIT};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, O_INIT};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, O_IN};
        tbl[5]  = '{0, 1, 0, 0, 1, 0, O_IN_WR};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, O_PB};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, O_PB};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, O_PB};
        tbl[9]  = '{0, 0, 0, 0, 1, 0, O_PB_ADV};
        tbl[10] = '{0, 0, 1, 0, 1, 0, O_PB_END};
        tbl[11] = '{0, 1, 0, 1, 1, 0, O_RP_ADV};
        tbl[12] = '{0, 1, 1, 1, 1, 0, O_RP};
        tbl[13] = '{0, 1, 0, 0, 1, 0, O_IN};
        tbl[14] = '{0, 0, 0, 0, 1, 0, O_IN};
        tbl[15] = '{0, 1, 0, 0, 0, 0, O_IN};
        tbl[16] = '{0, 0, 0, 0, 0, 0, O_IN};
        tbl[17] = '{0, 1, 0, 0, 1, 0, O_IN_WR};
        tbl[18] = '{0, 1, 1, 0, 1, 0, O_PB_END};
        tbl[19] = '{0, 0, 0, 0, 1, 0, O_RP};
        tbl[20] = '{0, 1, 0, 0, 1, 0, O_RP_FAIL};
        tbl[21] = '{0, 0, 0, 0, 1, 0, O_DN};
        tbl[22] = '{0, 1, 0, 0, 1, 0, O_DN};
        tbl[23] = '{0, 1, 0, 0, 1, 0, O_DN};
        tbl[24] = '{0, 0, 0, 0, 1, 0, O_DN_ADV};
        tbl[25] = '{0, 0, 1, 0, 1, 0, O_DN_RST};
        tbl[26] = '{0, 0, 0, 0, 1, 0, O_DN};
        tbl[27] = '{0, 1, 0, 0, 1, 0, O_DN};
        tbl[28] = '{0, 0, 0, 0, 1, 0, O_DN};
        tbl[29] = '{0, 0, 0, 0, 1, 0, O_DN_ADV};
        tbl[30] = '{1, 0, 0, 0, 0, 0, O_INIT};
        tbl[31] = '{0, 0, 0, 0, 0, 0, O_INIT};
        tbl[32] = '{0, 0, 0, 0, 0, 0, O_IN};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].v, tbl[i].cel, tbl[i].pei,
                  tbl[i].leg, tbl[i].lvl);
            #1;
            chk($sformatf("vec%0d", i), int'(obs()), int'(tbl[i].exp));
        end

        // Held legal press: one write only.
        wcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 1, 0);
            #1;
            wcount += int'(w_en);
        end
        chk("held_wen", wcount, 1);

        // Hard level, window 2: first_ld only on the third write.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 1, 1);
            #1;
            chk($sformatf("hard_wen%0d", k), int'(w_en), 1);
            chk($sformatf("hard_first%0d", k), int'(first_ld),
                (k == 2) ? 1 : 0);
            @(negedge clk);
            drive(0, 0, 1, 0, 1, 1);
            @(negedge clk);
            drive(0, 0, 1, 0, 1, 1);
        end
        chk("hard_count", int'(dut.count_q), 2);

        // Reset in the middle of a playback dwell.
        do_reset();
        @(negedge clk);
        drive(0, 1, 0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_dwell", int'(dut.u_timer.cnt_q), 2);
        chk("mid_count", int'(dut.count_q), 1);
        chk("mid_mode", int'(mode_leds), int'(MODE_PLAYBACK));
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_state", int'(dut.state_q), int'(S_INIT));
        chk("rst_dwell", int'(dut.u_timer.cnt_q), 0);
        chk("rst_count", int'(dut.count_q), 0);
        chk("rst_outs", int'(obs()), int'(O_INIT));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("post_rst_mode", int'(mode_leds), int'(MODE_INPUT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
